encode_instr_serializer: RTL
============================

// Module: encode_instr_serializer
// PURPOSE
//  Inverse of the opcode/operand decode path: accepts one decoded x86 instruction record
//  (opcode byte, 2-byte escape flag, embedded reg, ModRM, SIB, disp, imm) on a valid/ready
//  handshake and emits its machine-code bytes, one byte per cycle, on a second valid/ready stream.
//  Used to regenerate instruction bytes for trace re-checking and for decoder self-test.
// PARAMETERS
//  MAX_LEN   11   max encoded length in bytes (88-bit decode window); longer records rejected
// PORTS
//  clk          in   1   clock
//  rst          in   1   reset, asynchronous, active-high
//  in_valid     in   1   record valid
//  in_ready     out  1   serializer idle, record accepted when in_valid&&in_ready
//  in_opc       in   8   primary opcode byte (after any 0x0F escape)
//  in_is_2byte  in   1   prefix 0x0F escape
//  in_reg_emb   in   1   register embedded in opc[2:0]
//  in_reg       in   3   embedded register number
//  in_has_modrm in   1   ModRM byte present
//  in_modrm     in   8   ModRM byte
//  in_has_sib   in   1   SIB byte present
//  in_sib       in   8   SIB byte
//  in_disp_len  in   3   displacement bytes: 0, 1 or 4
//  in_disp      in  32   displacement, little-endian emitted
//  in_imm_len   in   3   immediate bytes: 0, 1, 2 or 4
//  in_imm       in  32   immediate, little-endian emitted
//  out_valid    out  1   out_byte valid
//  out_ready    in   1   consumer accepts byte
//  out_byte     out  8   encoded byte
//  out_last     out  1   final byte of instruction
//  instr_len    out  4   encoded length of current/last instruction
//  err          out  1   one-cycle pulse: record rejected
// BEHAVIOUR
//  - Reset (async): state IDLE, out_valid/out_last/err=0, out_byte=0, instr_len=0, idx=0;
//    in_ready forced 0 while rst high, 1 in IDLE otherwise.
//  - States: IDLE -> (accept, legal) EMIT; IDLE -> (accept, illegal) ERR; ERR -> IDLE after
//    1 cycle (err=1 only in ERR); EMIT -> IDLE the cycle after out_last byte is accepted.
//  - Accept in cycle N captures all fields into internal regs; first byte valid at N+1.
//  - Illegal: disp_len not in {0,1,4}; imm_len not in {0,1,2,4}; has_sib without has_modrm;
//    reg_emb with has_modrm; total length > MAX_LEN. Illegal records emit no bytes.
//  - Length = is_2byte + 1 + has_modrm + has_sib + disp_len + imm_len (4-bit, computed at accept,
//    latched to instr_len, held until next accept).
//  - Byte order: [0x0F], opc (reg_emb: {opc[7:3],reg}, else opc unmodified), ModRM, SIB,
//    disp bytes LSB first, imm bytes LSB first.
//  - idx counter 0..len-1 advances only on out_valid&&out_ready; out_byte/out_last stable while
//    stalled. out_last = (idx == len-1). Throughput 1 byte/cycle with out_ready high.
//  - in_ready=0 throughout EMIT/ERR; in_valid ignored there (no queuing).
//  - Reset mid-stream: emission abandoned, next record starts at byte 0.
// CONFIGURATION
//  ENCODE_WINDOW_EN defined: extra outputs window[87:0], window_is_2byte, window_valid.
//    Emitted bytes other than the 0x0F escape are packed unescaped from bit 0 (opc in [7:0]),
//    zero-padded; window_valid pulses 1 cycle after out_last accepted; window held until
//    next accept, cleared to 0 on reset. Directly consumable by the decode path.
//  Not defined: these ports and registers do not exist; all other behaviour identical.
// TESTING
//  1. opc=0x50 reg_emb reg=3, nothing else -> one byte 0x53, out_last=1, instr_len=1.
//  2. is_2byte opc=0xAF modrm=0x45 disp_len=1 disp=0x08 -> 0F AF 45 08, last on 4th, len=4.
//  3. opc=0x81 modrm=0xC0 imm_len=4 imm=0x12345678, out_ready low 3 cycles at byte 2
//     -> 0xC0 held stable; full stream 81 C0 78 56 34 12.
//  4. is_2byte+modrm+sib+disp4+imm4 (len 12) -> err=1 one cycle, out_valid never set,
//     in_ready=1 next cycle; also disp_len=2 -> err.
//  5. rst asserted after 2nd byte of test 3 -> out_valid=0 immediately; next record emits
//     from its first byte.
//  6. ENCODE_WINDOW_EN, test 2 record -> window=88'h0845AF, window_is_2byte=1,
//     window_valid one cycle after 0x08 accepted.

Source files
------------

// File: rtl/encode_instr_serializer.sv
// Serializes one decoded x86 instruction record into its machine-code bytes, one per cycle.
// Optional ENCODE_WINDOW_EN adds a packed, unescaped 88-bit window of the last legal record.
module encode_instr_serializer #(
  parameter int unsigned MAX_LEN = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_opc,
  input  logic        in_is_2byte,
  input  logic        in_reg_emb,
  input  logic [2:0]  in_reg,
  input  logic        in_has_modrm,
  input  logic [7:0]  in_modrm,
  input  logic        in_has_sib,
  input  logic [7:0]  in_sib,
  input  logic [2:0]  in_disp_len,
  input  logic [31:0] in_disp,
  input  logic [2:0]  in_imm_len,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        out_last,
  output logic [3:0]  instr_len,
`ifdef ENCODE_WINDOW_EN
  output logic [87:0] window,
  output logic        window_is_2byte,
  output logic        window_valid,
`endif
  output logic        err
);

  localparam int unsigned WinW = 8 * MAX_LEN;

  typedef enum logic [1:0] {StIdle, StEmit, StErr} state_e;

  state_e          state_q, state_d;
  logic [WinW-1:0] shreg_q, shreg_d;
  logic [3:0]      idx_q, idx_d;
  logic [3:0]      len_q, len_d;

  logic [31:0]     disp_m, imm_m;
  logic [7:0]      opc_eff;
  logic [WinW-1:0] body, enc;
  logic [4:0]      tot_len;
  logic            legal, accept;

  // Build the byte string back to front so each field lands after its predecessors.
  always_comb begin
    disp_m = 32'h0;
    unique case (in_disp_len)
      3'd1:    disp_m = {24'h0, in_disp[7:0]};
      3'd4:    disp_m = in_disp;
      default: disp_m = 32'h0;
    endcase
    imm_m = 32'h0;
    unique case (in_imm_len)
      3'd1:    imm_m = {24'h0, in_imm[7:0]};
      3'd2:    imm_m = {16'h0, in_imm[15:0]};
      3'd4:    imm_m = in_imm;
      default: imm_m = 32'h0;
    endcase
    opc_eff = in_reg_emb ? {in_opc[7:3], in_reg} : in_opc;
    body = WinW'(imm_m);
    body = (body << {in_disp_len, 3'b000}) | WinW'(disp_m);
    if (in_has_sib)   body = {body[WinW-9:0], in_sib};
    if (in_has_modrm) body = {body[WinW-9:0], in_modrm};
    body = {body[WinW-9:0], opc_eff};
    enc  = in_is_2byte ? {body[WinW-9:0], 8'h0F} : body;
    tot_len = 5'(in_is_2byte) + 5'd1 + 5'(in_has_modrm) + 5'(in_has_sib)
            + 5'(in_disp_len) + 5'(in_imm_len);
    legal = (in_disp_len == 3'd0 || in_disp_len == 3'd1 || in_disp_len == 3'd4)
         && (in_imm_len == 3'd0 || in_imm_len == 3'd1 || in_imm_len == 3'd2
             || in_imm_len == 3'd4)
         && !(in_has_sib && !in_has_modrm)
         && !(in_reg_emb && in_has_modrm)
         && (tot_len <= 5'(MAX_LEN));
  end

  assign in_ready  = (state_q == StIdle) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == StEmit);
  assign out_byte  = out_valid ? shreg_q[7:0] : 8'h00;
  assign out_last  = out_valid && (idx_q == len_q - 4'd1);
  assign instr_len = len_q;
  assign err       = (state_q == StErr);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    len_d   = len_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          len_d = tot_len[3:0];
          if (legal) begin
            state_d = StEmit;
            shreg_d = enc;
            idx_d   = 4'd0;
          end else begin
            state_d = StErr;
          end
        end
      end
      StEmit: begin
        if (out_ready) begin
          if (out_last) begin
            state_d = StIdle;
          end else begin
            shreg_d = shreg_q >> 8;
            idx_d   = idx_q + 4'd1;
          end
        end
      end
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      idx_q   <= 4'd0;
      len_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
    end
  end

`ifdef ENCODE_WINDOW_EN
  logic [87:0] window_q;
  logic        window_is_2byte_q, window_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window_q          <= '0;
      window_is_2byte_q <= 1'b0;
      window_valid_q    <= 1'b0;
    end else begin
      window_valid_q <= out_valid && out_ready && out_last;
      if (accept && legal) begin
        window_q          <= 88'(body);
        window_is_2byte_q <= in_is_2byte;
      end
    end
  end

  assign window          = window_q;
  assign window_is_2byte = window_is_2byte_q;
  assign window_valid    = window_valid_q;
`endif

endmodule
